// File: rtl/des_key_pkg.sv
// Shared types, DES shift schedule, PC-2 table and half-rotation helpers
// for the sequential DES round-key generator.
package des_key_pkg;

  localparam int NUM_ROUNDS = 16;
  localparam int HALF_W     = 28;

  typedef logic [HALF_W-1:0]   half_t;
  typedef logic [2*HALF_W-1:0] cd_t;
  typedef logic [47:0]         subkey_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam logic [1:0] SHIFT_SCHED [1:NUM_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // 1-based DES bit numbers; bit n of the C/D pair lives at cd[n-1]
  localparam logic [5:0] PC2_TAB [0:47] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic logic [1:0] shift_amt(input logic [4:0] round);
    logic [1:0] s;
    s = 2'd2;
    for (int r = 1; r <= NUM_ROUNDS; r++) begin
      s = (round == 5'(r)) ? SHIFT_SCHED[r] : s;
    end
    return s;
  endfunction

  // DES left rotate: new h[i] = h[(i+s) mod 28]
  function automatic half_t des_rotl(input half_t h, input logic [1:0] s);
    half_t r;
    if (s == 2'd1) begin
      r = {h[0], h[27:1]};
    end else begin
      r = {h[1:0], h[27:2]};
    end
    return r;
  endfunction

  function automatic half_t des_rotr(input half_t h, input logic [1:0] s);
    half_t r;
    if (s == 2'd1) begin
      r = {h[26:0], h[27]};
    end else begin
      r = {h[25:0], h[27:26]};
    end
    return r;
  endfunction

  function automatic logic is_weak(input cd_t cd);
    logic c_ok;
    logic d_ok;
    c_ok = (cd[27:0] == 28'h0000000) || (cd[27:0] == 28'hFFFFFFF);
    d_ok = (cd[55:28] == 28'h0000000) || (cd[55:28] == 28'hFFFFFFF);
    return c_ok && d_ok;
  endfunction

endpackage

// File: rtl/key_permutation2.sv
// Combinational DES PC-2: selects 48 of the 56 C/D bits to form one subkey.
module key_permutation2
  import des_key_pkg::*;
(
  input  logic [55:0] i_cd,
  output logic [47:0] o_subkey
);

  for (genvar j = 0; j < 48; j++) begin : g_pc2
    localparam int SRC = int'(PC2_TAB[j]) - 1;
    assign o_subkey[j] = i_cd[SRC];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: one PC-2 subkey per handshake, K1..K16 or K16..K1.
// Define DES_KEY_SCHED_WEAK_KEY_EN to add the weak_key detection output.
module des_key_schedule
  import des_key_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        load,
  input  logic        decrypt,
  input  logic [55:0] key_in,
  input  logic        subkey_ready,
  output logic [47:0] subkey_out,
  output logic [3:0]  subkey_idx,
  output logic        subkey_valid,
  output logic        busy,
  output logic        done
`ifdef DES_KEY_SCHED_WEAK_KEY_EN
  ,
  output logic        weak_key
`endif
);

  state_t     r_state;
  state_t     w_state_nxt;
  cd_t        r_cd;
  cd_t        w_cd_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_dir;
  logic       w_dir_nxt;
  logic       r_done;
  logic       w_done_nxt;
  logic       w_last;
  logic [1:0] w_shift;
  subkey_t    w_subkey;

  // Encrypt moves C(k+1) -> C(k+2); decrypt moves C(k+1) -> C(k), undoing shift[k+1]
  assign w_shift = r_dir ? shift_amt({1'b0, r_cnt} + 5'd1) : shift_amt({1'b0, r_cnt} + 5'd2);
  assign w_last  = r_dir ? (r_cnt == 4'd0) : (r_cnt == 4'd15);

  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_state_nxt = EMIT;
          w_dir_nxt   = decrypt;
          if (decrypt) begin
            w_cd_nxt  = key_in;
            w_cnt_nxt = 4'd15;
          end else begin
            w_cd_nxt  = {des_rotl(key_in[55:28], 2'd1), des_rotl(key_in[27:0], 2'd1)};
            w_cnt_nxt = 4'd0;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      EMIT: begin
        if (subkey_ready) begin
          if (w_last) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else if (r_dir) begin
            w_cd_nxt  = {des_rotr(r_cd[55:28], w_shift), des_rotr(r_cd[27:0], w_shift)};
            w_cnt_nxt = r_cnt - 4'd1;
          end else begin
            w_cd_nxt  = {des_rotl(r_cd[55:28], w_shift), des_rotl(r_cd[27:0], w_shift)};
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end else begin
          w_state_nxt = EMIT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cd   <= '0;
      r_cnt  <= 4'd0;
      r_dir  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cd   <= w_cd_nxt;
      r_cnt  <= w_cnt_nxt;
      r_dir  <= w_dir_nxt;
      r_done <= w_done_nxt;
    end
  end

`ifdef DES_KEY_SCHED_WEAK_KEY_EN
  logic r_weak;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_weak <= 1'b0;
    end else if ((r_state == IDLE) && load) begin
      r_weak <= is_weak(key_in);
    end else begin
      r_weak <= r_weak;
    end
  end

  assign weak_key = r_weak;
`endif

  key_permutation2 u_pc2 (
    .i_cd     (r_cd),
    .o_subkey (w_subkey)
  );

  assign subkey_out   = w_subkey;
  assign subkey_idx   = r_cnt;
  assign subkey_valid = (r_state == EMIT);
  assign busy         = (r_state != IDLE);
  assign done         = r_done;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: cumulative-rotation reference model
// checked every cycle, plus directed vectors pinned to the classic DES example key.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        load;
  logic        decrypt;
  logic [55:0] key_in;
  logic        subkey_ready;
  logic [47:0] subkey_out;
  logic [3:0]  subkey_idx;
  logic        subkey_valid;
  logic        busy;
  logic        done;
`ifdef DES_KEY_SCHED_WEAK_KEY_EN
  logic        weak_key;
`endif

  des_key_schedule dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .load         (load),
    .decrypt      (decrypt),
    .key_in       (key_in),
    .subkey_ready (subkey_ready),
    .subkey_out   (subkey_out),
    .subkey_idx   (subkey_idx),
    .subkey_valid (subkey_valid),
    .busy         (busy),
    .done         (done)
`ifdef DES_KEY_SCHED_WEAK_KEY_EN
    ,
    .weak_key     (weak_key)
`endif
  );

  always #5 clk = ~clk;

  localparam int PC2_B [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // MSB-first hex (DES bit 1 = MSB) to the DUT's bit-0 = DES-bit-1 layout
  function automatic logic [47:0] rev48(input logic [47:0] v);
    logic [47:0] r;
    for (int j = 0; j < 48; j++) r[j] = v[47-j];
    return r;
  endfunction

  function automatic logic [55:0] make_key(input logic [27:0] c0, input logic [27:0] d0);
    logic [55:0] k;
    for (int i = 0; i < 28; i++) begin
      k[i]      = c0[27-i];
      k[28 + i] = d0[27-i];
    end
    return k;
  endfunction

  // Subkey K<round> from C0/D0 via the total left-rotation accumulated up to that round
  function automatic logic [47:0] model_subkey(input logic [55:0] k, input int round);
    int total;
    logic [55:0] cd;
    logic [47:0] sk;
    total = 0;
    for (int r = 1; r <= round; r++) total += (r == 1 || r == 2 || r == 9 || r == 16) ? 1 : 2;
    for (int i = 0; i < 28; i++) begin
      cd[i]      = k[(i + total) % 28];
      cd[28 + i] = k[28 + ((i + total) % 28)];
    end
    for (int j = 0; j < 48; j++) sk[j] = cd[PC2_B[j] - 1];
    return sk;
  endfunction

  logic [55:0] KEY;
  logic [47:0] K1R, K2R, K16R;

  // Reference model: position within the 16-subkey sequence, advanced per accept
  logic        m_active;
  logic        m_done;
  logic        m_dir;
  logic [3:0]  m_pos;
  logic [55:0] m_key;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_dir    <= 1'b0;
      m_pos    <= 4'd0;
      m_key    <= '0;
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (load) begin
          m_active <= 1'b1;
          m_dir    <= decrypt;
          m_key    <= key_in;
          m_pos    <= 4'd0;
        end
      end else if (subkey_ready) begin
        if (m_pos == 4'd15) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end else begin
          m_pos <= m_pos + 4'd1;
        end
      end
    end
  end

  logic        p_stall = 1'b0;
  logic [47:0] p_sub   = '0;
  logic [3:0]  p_idx   = '0;

  // Per-cycle comparison against the model, plus hold-stable check on stalls
  always @(negedge clk) begin
    if (n_rst) begin
      chk("busy", 64'(busy), 64'(m_active));
      chk("valid", 64'(subkey_valid), 64'(m_active));
      chk("done", 64'(done), 64'(m_done));
      if (m_active) begin
        chk("idx", 64'(subkey_idx), 64'(m_dir ? (4'd15 - m_pos) : m_pos));
        chk("subkey", 64'(subkey_out),
            64'(model_subkey(m_key, int'(m_dir ? (4'd15 - m_pos) : m_pos) + 1)));
      end
      if (p_stall) begin
        chk("hold_sub", 64'(subkey_out), 64'(p_sub));
        chk("hold_idx", 64'(subkey_idx), 64'(p_idx));
      end
      p_stall <= subkey_valid && !subkey_ready;
      p_sub   <= subkey_out;
      p_idx   <= subkey_idx;
    end else begin
      p_stall <= 1'b0;
    end
  end

  logic [47:0] ref_q[$];
  logic [47:0] got_q[$];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic dec, input logic [55:0] k);
    key_in  = k;
    decrypt = dec;
    load    = 1'b1;
    step();
    load    = 1'b0;
    decrypt = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      step();
      n++;
    end
    chk("wait_done", 64'(done), 64'd1);
  endtask

  // Ready held high; literal pins at the ends; optional ignored load mid-run
  task automatic stream(input logic dec, input int mid_at, input logic capture);
    for (int c = 1; c <= 16; c++) begin
      if (capture) ref_q.push_back(subkey_out);
      if (!dec && c == 1)  chk("enc_K1", 64'(subkey_out), 64'(K1R));
      if (!dec && c == 2)  chk("enc_K2", 64'(subkey_out), 64'(K2R));
      if (!dec && c == 16) chk("enc_K16", 64'(subkey_out), 64'(K16R));
      if (dec && c == 1) begin
        chk("dec_first_idx", 64'(subkey_idx), 64'd15);
        chk("dec_first_K16", 64'(subkey_out), 64'(K16R));
      end
      if (dec && c == 16) begin
        chk("dec_last_idx", 64'(subkey_idx), 64'd0);
        chk("dec_last_K1", 64'(subkey_out), 64'(K1R));
      end
      if (c == mid_at) begin
        load    = 1'b1;
        decrypt = 1'b1;
        key_in  = ~KEY;
      end
      step();
      load    = 1'b0;
      decrypt = 1'b0;
      key_in  = KEY;
    end
    chk("seq_done", 64'(done), 64'd1);
    chk("seq_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int acc;
    KEY  = make_key(28'hF0CCAAF, 28'h556678F);
    K1R  = rev48(48'h1B02EFFC7072);
    K2R  = rev48(48'h79AED9DBC9E5);
    K16R = rev48(48'hCB3D8B0E17F5);

    n_rst = 1'b1; load = 1'b0; decrypt = 1'b0; key_in = '0; subkey_ready = 1'b1;
    #1 n_rst = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(subkey_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_idx", 64'(subkey_idx), 64'd0);
    chk("rst_sub", 64'(subkey_out), 64'd0);
`ifdef DES_KEY_SCHED_WEAK_KEY_EN
    chk("rst_weak", 64'(weak_key), 64'd0);
`endif
    step();
    step();
    n_rst = 1'b1;
    step();

    chk("model_K1", 64'(model_subkey(KEY, 1)), 64'(K1R));
    chk("model_K2", 64'(model_subkey(KEY, 2)), 64'(K2R));
    chk("model_K16", 64'(model_subkey(KEY, 16)), 64'(K16R));

    // Encrypt, then decrypt loaded in the done cycle, then encrypt with stray load
    start(1'b0, KEY);
    stream(1'b0, 0, 1'b1);
    start(1'b1, KEY);
    stream(1'b1, 0, 1'b0);
    start(1'b0, KEY);
    stream(1'b0, 5, 1'b0);

    // Random backpressure
    step();
    start(1'b0, KEY);
    acc = 0;
    for (int cyc = 0; cyc < 300 && acc < 16; cyc++) begin
      subkey_ready = 1'($urandom_range(0, 1));
      if (subkey_valid && subkey_ready) begin
        got_q.push_back(subkey_out);
        acc++;
      end
      step();
    end
    subkey_ready = 1'b1;
    chk("rr_accepts", 64'(acc), 64'd16);
    chk("rr_done", 64'(done), 64'd1);
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
      chk("rr_seq", 64'(got_q[i]), 64'(ref_q[i]));

    // Reset at round 8
    step();
    start(1'b0, KEY);
    for (int c = 1; c < 8; c++) step();
    chk("pre_rst_idx", 64'(subkey_idx), 64'd7);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(subkey_valid), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_idx", 64'(subkey_idx), 64'd0);
    step();
    n_rst = 1'b1;
    step();
    start(1'b0, KEY);
    chk("post_rst_K1", 64'(subkey_out), 64'(K1R));
    chk("post_rst_idx", 64'(subkey_idx), 64'd0);
    wait_done();

`ifdef DES_KEY_SCHED_WEAK_KEY_EN
    step();
    start(1'b0, 56'd0);
    chk("weak_zero", 64'(weak_key), 64'd1);
    chk("weak_sub0", 64'(subkey_out), 64'd0);
    wait_done();
    chk("weak_held", 64'(weak_key), 64'd1);
    start(1'b0, KEY);
    chk("weak_normal", 64'(weak_key), 64'd0);
    wait_done();
`endif

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
